// File: rtl/traffic_phase_arbiter.sv
// Sensor-driven NS/EW right-of-way scheduler: min/max green, yellow and all-red clearance,
// all timed in ticks of an external strobe. Lights, demands and phase pulse are registered.
module traffic_phase_arbiter #(
    parameter int unsigned MIN_GREEN = 5,
    parameter int unsigned MAX_GREEN = 20,
    parameter int unsigned YELLOW    = 3,
    parameter int unsigned ALL_RED   = 1,
    parameter int unsigned CNT_W     = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_carNS,
    input  logic       i_carEW,
    output logic [2:0] o_NSlights,
    output logic [2:0] o_EWlights,
    output logic       o_demandNS,
    output logic       o_demandEW,
    output logic       o_phaseChange
);

    typedef enum logic [2:0] {
        StNsGrn, StNsYel, StRedToEw, StEwGrn, StEwYel, StRedToNs
    } state_t;

    localparam logic [CNT_W:0] L_MIN = MIN_GREEN[CNT_W:0];
    localparam logic [CNT_W:0] L_MAX = MAX_GREEN[CNT_W:0];
    localparam logic [CNT_W:0] L_YEL = YELLOW[CNT_W:0];
    localparam logic [CNT_W:0] L_RED = ALL_RED[CNT_W:0];

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_nsLights;
    logic [2:0]       r_ewLights;
    logic             r_demandNS;
    logic             r_demandEW;
    logic             r_phaseChange;

    state_t           w_state_next;
    state_t           w_succ;
    logic [CNT_W:0]   w_elapsed;
    logic [CNT_W-1:0] w_timer_sat;
    logic             w_setNS;
    logic             w_setEW;
    logic             w_oppNS;
    logic             w_oppEW;
    logic             w_go;

    // Packed {ns, ew}; each field is {red, yellow, green}.
    function automatic logic [5:0] lights_of(input state_t s);
        unique case (s)
            StNsGrn: lights_of = {3'b001, 3'b100};
            StNsYel: lights_of = {3'b010, 3'b100};
            StEwGrn: lights_of = {3'b100, 3'b001};
            StEwYel: lights_of = {3'b100, 3'b010};
            default: lights_of = {3'b100, 3'b100};
        endcase
    endfunction

    always_comb begin
        w_setNS     = i_carNS && (r_state != StNsGrn);
        w_setEW     = i_carEW && (r_state != StEwGrn);
        // A request latched this very cycle already counts for this tick's decision.
        w_oppEW     = r_demandEW || w_setEW;
        w_oppNS     = r_demandNS || w_setNS;
        w_elapsed   = {1'b0, r_timer} + {{CNT_W{1'b0}}, 1'b1};
        w_timer_sat = (w_elapsed > L_MAX) ? L_MAX[CNT_W-1:0] : w_elapsed[CNT_W-1:0];

        w_go = 1'b0;
        if (i_tick) begin
            unique case (r_state)
                StNsGrn: w_go = ((w_elapsed >= L_MIN) && w_oppEW && !i_carNS) ||
                                ((w_elapsed >= L_MAX) && w_oppEW);
                StEwGrn: w_go = ((w_elapsed >= L_MIN) && w_oppNS && !i_carEW) ||
                                ((w_elapsed >= L_MAX) && w_oppNS);
                StNsYel, StEwYel:     w_go = (w_elapsed == L_YEL);
                StRedToEw, StRedToNs: w_go = (w_elapsed == L_RED);
                default:              w_go = 1'b0;
            endcase
        end

        unique case (r_state)
            StNsGrn:   w_succ = StNsYel;
            StNsYel:   w_succ = StRedToEw;
            StRedToEw: w_succ = StEwGrn;
            StEwGrn:   w_succ = StEwYel;
            StEwYel:   w_succ = StRedToNs;
            default:   w_succ = StNsGrn;
        endcase
        w_state_next = w_go ? w_succ : r_state;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StNsGrn;
            r_timer       <= '0;
            r_nsLights    <= 3'b001;
            r_ewLights    <= 3'b100;
            r_demandNS    <= 1'b0;
            r_demandEW    <= 1'b0;
            r_phaseChange <= 1'b0;
        end else begin
            if (i_tick) begin
                r_timer <= w_go ? '0 : w_timer_sat;
            end
            r_state                    <= w_state_next;
            {r_nsLights, r_ewLights}   <= lights_of(w_state_next);
            r_phaseChange              <= w_go;
            // Entering a direction's green serves its request, so clear beats set.
            r_demandNS <= (w_go && (w_state_next == StNsGrn)) ? 1'b0 : (r_demandNS || w_setNS);
            r_demandEW <= (w_go && (w_state_next == StEwGrn)) ? 1'b0 : (r_demandEW || w_setEW);
        end
    end

    assign o_NSlights    = r_nsLights;
    assign o_EWlights    = r_ewLights;
    assign o_demandNS    = r_demandNS;
    assign o_demandEW    = r_demandEW;
    assign o_phaseChange = r_phaseChange;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Self-checking bench for traffic_phase_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a phase-index/tick-count reference model.
module tb_traffic_phase_arbiter;

    localparam int MIN_G = 5;
    localparam int MAX_G = 20;
    localparam int YEL   = 3;
    localparam int RED   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       car_ns = 1'b0;
    logic       car_ew = 1'b0;
    logic [2:0] ns_l;
    logic [2:0] ew_l;
    logic       dem_ns;
    logic       dem_ew;
    logic       pc;

    traffic_phase_arbiter #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW(YEL), .ALL_RED(RED), .CNT_W(5)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_carNS(car_ns), .i_carEW(car_ew),
        .o_NSlights(ns_l), .o_EWlights(ew_l), .o_demandNS(dem_ns), .o_demandEW(dem_ew),
        .o_phaseChange(pc)
    );

    always #5 clk = ~clk;

    wire [8:0] obs = {ns_l, ew_l, dem_ns, dem_ew, pc};

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0..5 in cycle order starting at NS green, plus elapsed tick count.
    int         m_phase = 0;
    int         m_timer = 0;
    bit         m_dns   = 1'b0;
    bit         m_dew   = 1'b0;
    bit         m_pc    = 1'b0;
    logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    function automatic logic [8:0] expv();
        return {ns_tab[m_phase], ew_tab[m_phase], m_dns, m_dew, m_pc};
    endfunction

    task automatic drive_cycle(input bit r, input bit t, input bit ns, input bit ew);
        int e;
        int nph;
        bit go, opp, own, set_ns, set_ew;
        rst = r; tick = t; car_ns = ns; car_ew = ew;
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_timer = 0; m_dns = 0; m_dew = 0; m_pc = 0;
        end else begin
            set_ns = ns && (m_phase != 0);
            set_ew = ew && (m_phase != 3);
            go = 1'b0;
            if (t) begin
                e = m_timer + 1;
                if (m_phase == 1 || m_phase == 4) go = (e == YEL);
                else if (m_phase == 2 || m_phase == 5) go = (e == RED);
                else begin
                    opp = (m_phase == 0) ? (m_dew | set_ew) : (m_dns | set_ns);
                    own = (m_phase == 0) ? ns : ew;
                    go  = (e >= MIN_G && opp && !own) || (e >= MAX_G && opp);
                end
                m_timer = go ? 0 : ((e > MAX_G) ? MAX_G : e);
            end
            nph   = go ? (m_phase + 1) % 6 : m_phase;
            m_dns = (go && nph == 0) ? 1'b0 : (m_dns | set_ns);
            m_dew = (go && nph == 3) ? 1'b0 : (m_dew | set_ew);
            m_phase = nph;
            m_pc    = go;
        end
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1, 1, 1, 1);
        n_checks++;
        if (obs !== 9'b001_100_0_0_0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs, 9'b001_100_0_0_0);
        end
    endtask

    task automatic test_idle();
        int pulses = 0;
        drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            drive_cycle(0, 1, 0, 0);
            pulses += pc;
            n_checks++;
            if (obs !== 9'b001_100_0_0_0) begin
                n_fail++;
                $display("FAIL idle cyc %0d: got %b want %b", i, obs, 9'b001_100_0_0_0);
            end
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL idle_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_ew_request();
        int pulses = 0;
        drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(0, 1, 0, i == 2);
            pulses += pc;
            n_checks++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL ew_request cyc %0d: got %b want %b", i, obs, expv());
            end
            if (i == 4) begin
                n_checks++;
                if (ns_l !== 3'b010) begin
                    n_fail++;
                    $display("FAIL ew_request_yellow: got %b want 010", ns_l);
                end
            end
        end
        n_checks++;
        if (pulses !== 3 || ew_l !== 3'b001 || dem_ew !== 1'b0) begin
            n_fail++;
            $display("FAIL ew_request_end: pulses %0d ew %b dem %b want 3 001 0",
                     pulses, ew_l, dem_ew);
        end
    endtask

    task automatic test_both_held();
        int first_reentry = -1;
        drive_cycle(1, 0, 0, 0);
        for (int k = 1; k <= 100; k++) begin
            drive_cycle(0, 1, 1, 1);
            if (pc && ns_l == 3'b001 && first_reentry < 0) first_reentry = k;
            n_checks++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL both_held cyc %0d: got %b want %b", k, obs, expv());
            end
        end
        n_checks++;
        if (first_reentry !== 48) begin
            n_fail++;
            $display("FAIL both_held_period: got %0d want 48", first_reentry);
        end
    endtask

    task automatic test_slow_tick();
        int  pulses = 0;
        bit  prev_tick;
        drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < 120; i++) begin
            prev_tick = (i % 4 == 3);
            drive_cycle(0, prev_tick, 0, i == 5);
            pulses += pc;
            n_checks++;
            if (obs !== expv() || (pc && !prev_tick)) begin
                n_fail++;
                $display("FAIL slow_tick cyc %0d: got %b want %b tick %b", i, obs, expv(),
                         prev_tick);
            end
        end
        n_checks++;
        if (pulses !== 3) begin
            n_fail++;
            $display("FAIL slow_tick_pulses: got %0d want 3", pulses);
        end
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < 200 && !reached; i++) begin
            drive_cycle(0, 1, 1, 1);
            reached = (m_phase == 4);
        end
        n_checks++;
        if (!reached || ew_l !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_mid_reach: got ew %b want 010", ew_l);
        end
        drive_cycle(1, 1, 1, 1);
        n_checks++;
        if (obs !== 9'b001_100_0_0_0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b want %b", obs, 9'b001_100_0_0_0);
        end
        for (int i = 0; i < 30; i++) begin
            drive_cycle(0, 1, 0, 1);
            n_checks++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc %0d: got %b want %b", i, obs, expv());
            end
        end
    endtask

    task automatic test_late_request();
        drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) drive_cycle(0, 1, 0, 0);
        drive_cycle(0, 1, 0, 1);
        n_checks++;
        if (ns_l !== 3'b010 || pc !== 1'b1 || obs !== expv()) begin
            n_fail++;
            $display("FAIL late_request: got %b want %b", obs, expv());
        end
    endtask

    task automatic test_random();
        bit t, ns, ew, r;
        ns = 0; ew = 0;
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) ns = ~ns;
            if ($urandom_range(0, 7) == 0) ew = ~ew;
            r = ($urandom_range(0, 399) == 0);
            drive_cycle(r, t, ns, ew);
            n_checks++;
            if (obs !== expv()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs, expv());
            end
            n_checks++;
            if (!$onehot(ns_l) || !$onehot(ew_l) || (!ns_l[2] && !ew_l[2])) begin
                n_fail++;
                $display("FAIL random_invariant cyc %0d: ns %b ew %b", i, ns_l, ew_l);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_idle();
        test_ew_request();
        test_both_held();
        test_slow_tick();
        test_reset_mid();
        test_late_request();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_arbiter.md
Name: traffic_phase_arbiter

Overview:
- Demand-driven right-of-way scheduler for a two-way (NS/EW) intersection.
- Arbitrates green between the NS and EW approaches from car-sensor requests, with minimum/maximum green, yellow and all-red clearance intervals.
- Timing is counted in ticks of an external 1-cycle strobe; drives the NS/EW light vectors directly.
- Sits alongside the existing timer/FSM light path as the sensor-aware controller variant.

Parameters:
- MIN_GREEN, 5, minimum green length in ticks (≥1).
- MAX_GREEN, 20, green length in ticks after which a waiting opposing demand forces a change (≥ MIN_GREEN).
- YELLOW, 3, yellow length in ticks (≥1).
- ALL_RED, 1, all-red clearance length in ticks (≥1).
- CNT_W, 5, phase timer width; must hold MAX_GREEN.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_tick  in  1  timing strobe, one-cycle pulse; all timing counts these.
- i_carNS  in  1  NS car sensor, level, synchronous to i_clk.
- i_carEW  in  1  EW car sensor, level, synchronous to i_clk.
- o_NSlights  out  3  {red, yellow, green}, one-hot, registered.
- o_EWlights  out  3  {red, yellow, green}, one-hot, registered.
- o_demandNS  out  1  latched NS request pending.
- o_demandEW  out  1  latched EW request pending.
- o_phaseChange  out  1  one-cycle pulse on the cycle after any state transition.

Behaviour:
- States: NS_GRN, NS_YEL, RED_TO_EW, EW_GRN, EW_YEL, RED_TO_NS.
- Cycle order: NS_GRN→NS_YEL→RED_TO_EW→EW_GRN→EW_YEL→RED_TO_NS→NS_GRN.
- Lights per state:
  - NS_GRN: NS=001, EW=100.
  - NS_YEL: NS=010, EW=100.
  - RED_*: both 100.
  - EW_GRN: NS=100, EW=001.
  - EW_YEL: NS=100, EW=010.
- Reset: state=NS_GRN, timer=0, both demand latches=0, o_phaseChange=0, o_NSlights=001, o_EWlights=100. Reset has priority over all inputs and takes effect mid-phase on the next edge.
- Demand latches: the EW latch sets on any cycle with i_carEW=1 while the state is not EW_GRN, and clears on entry to EW_GRN. NS is symmetric. Set and clear in the same cycle: clear wins, because the request is being served.
- Timer: state changes occur only on cycles with i_tick=1. On such a cycle let e = timer+1.
  - Yellow state: transition when e == YELLOW.
  - RED_* state: transition when e == ALL_RED.
  - Green state (own = own-direction sensor level, opp = opposing demand latch): transition when (e ≥ MIN_GREEN && opp && !own) || (e ≥ MAX_GREEN && opp).
  - No transition: timer ← min(e, MAX_GREEN). The timer saturates; no wrap.
  - On transition: timer ← 0.
  - Cycles with i_tick=0 hold the timer and state.
- With no opposing demand, green rests indefinitely. The timer saturates at MAX_GREEN, so a late opposing request causes a change on its next tick.
- Demand latched on the same cycle as a tick is visible to that tick's green decision: the latch and its input are ORed into opp.
- Latency: lights and o_phaseChange update on the edge after the deciding tick cycle, i.e. 1 cycle.
- Both sensors high continuously: alternates and serves each direction MAX_GREEN ticks.
- Invariant: the two light vectors are never green/yellow simultaneously, and each vector is always one-hot.

Test Plan:
- Reset, then i_tick every cycle, no cars, 50 cycles → NS=001, EW=100 throughout; o_phaseChange never pulses.
- Reset; i_carEW pulse for 1 cycle at cycle 2; ticks every cycle, i_carNS=0 → NS yellow from cycle 5 (after 5 ticks), all-red 3 ticks later, EW green after 1 more tick; o_demandEW clears on EW green entry; 3 o_phaseChange pulses.
- i_carNS held 1 and i_carEW held 1 → NS green 20 ticks, yellow 3, red 1, EW green 20 ticks; the period repeats every 48 ticks.
- Ticks every 4th cycle with an EW request → all durations scale ×4; no transition occurs on non-tick cycles.
- Assert i_reset during EW_YEL → next edge: NS=001, EW=100, demands 0, timer 0.
- EW request arriving after 30 ticks of resting NS green → NS yellow on the next tick (timer saturated at 20).
